// File: rtl/axi_ram_wr_ctrl.sv
// AXI4 write-side controller: turns one AW/W burst at a time into single-beat RAM writes plus one B response.
// Optional build macro AXI_RAM_WR_4K_CHK_EN rejects INCR bursts that cross a 4 KB boundary.
module axi_ram_wr_ctrl #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic                              aclk,
   input  logic                              aresetn,
   input  logic                              aw_valid,
   output logic                              aw_ready,
   input  logic [ID_W-1:0]                   aw_id,
   input  logic [ADDR_W-1:0]                 aw_addr,
   input  logic [7:0]                        aw_len,
   input  logic [2:0]                        aw_size,
   input  logic [1:0]                        aw_burst,
   input  logic                              w_valid,
   output logic                              w_ready,
   input  logic [DATA_W-1:0]                 w_data,
   input  logic [DATA_W/8-1:0]               w_strb,
   input  logic                              w_last,
   output logic                              b_valid,
   input  logic                              b_ready,
   output logic [ID_W-1:0]                   b_id,
   output logic [1:0]                        b_resp,
   output logic                              ram_we,
   output logic [ADDR_W-$clog2(DATA_W/8)-1:0] ram_addr,
   output logic [DATA_W-1:0]                 ram_wdata,
   output logic [DATA_W/8-1:0]               ram_wstrb
);
   localparam int BYTES = DATA_W / 8;
   localparam int LSB   = $clog2(BYTES);
   localparam int WA_W  = ADDR_W - LSB;

   typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        len_q, len_d;
   logic [1:0]        burst_q, burst_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [8:0]        cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              run_q;
   logic              ram_we_q, ram_we_d;
   logic [WA_W-1:0]   ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic [BYTES-1:0]  ram_wstrb_q, ram_wstrb_d;
   logic [ID_W-1:0]   b_id_q, b_id_d;
   logic [1:0]        b_resp_q, b_resp_d;

   logic              aw_hs, w_hs, last_beat, wlast_bad, cross4k;
   logic [ADDR_W-1:0] aw_aligned;

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [7:0] len,
                                                   input logic [1:0] burst);
      logic [ADDR_W-1:0] m;
      m = ADDR_W'(((32'(len) + 32'd1) << LSB) - 32'd1);
      case (burst)
         2'b01:   next_addr = a + ADDR_W'(BYTES);
         2'b10:   next_addr = (a & ~m) | ((a + ADDR_W'(BYTES)) & m);
         default: next_addr = a;
      endcase
   endfunction

   function automatic logic burst_err(input logic [7:0] len, input logic [2:0] size,
                                      input logic [1:0] burst);
      logic e;
      e = (size != 3'(LSB)) || (burst == 2'b11);
      if (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
         e = 1'b1;
      burst_err = e;
   endfunction

   assign aw_aligned = aw_addr & ~ADDR_W'(BYTES - 1);
   assign aw_hs      = aw_valid & aw_ready;
   assign w_hs       = w_valid & w_ready;
   assign last_beat  = (cnt_q == {1'b0, len_q});
   assign wlast_bad  = (w_last != last_beat);

`ifdef AXI_RAM_WR_4K_CHK_EN
   assign cross4k = (aw_burst == 2'b01) &&
                    (((32'(aw_aligned) & 32'hFFF) + ((32'(aw_len) + 32'd1) << LSB)) > 32'h1000);
`else
   assign cross4k = 1'b0;
`endif

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         run_q       <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         ram_wstrb_q <= '0;
         b_id_q      <= '0;
         b_resp_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         run_q       <= 1'b1;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ram_wstrb_q <= ram_wstrb_d;
         b_id_q      <= b_id_d;
         b_resp_q    <= b_resp_d;
      end
   end

   // Burst context only matters once AW is accepted, so it carries no reset.
   always_ff @(posedge aclk) begin
      addr_q  <= addr_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      id_q    <= id_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (aw_hs) state_d = DATA;
         DATA:    if (w_hs && last_beat) state_d = RESP;
         RESP:    if (b_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      addr_d      = addr_q;
      len_d       = len_q;
      burst_d     = burst_q;
      id_d        = id_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ram_wstrb_d = ram_wstrb_q;
      b_id_d      = b_id_q;
      b_resp_d    = b_resp_q;
      if (aw_hs) begin
         addr_d  = aw_aligned;
         len_d   = aw_len;
         burst_d = aw_burst;
         id_d    = aw_id;
         cnt_d   = '0;
         err_d   = burst_err(aw_len, aw_size, aw_burst) | cross4k;
      end
      if (w_hs) begin
         // A misplaced w_last poisons this beat and every later one of the burst.
         ram_we_d    = ~err_q & ~wlast_bad;
         ram_addr_d  = addr_q[ADDR_W-1:LSB];
         ram_wdata_d = w_data;
         ram_wstrb_d = w_strb;
         addr_d      = next_addr(addr_q, len_q, burst_q);
         cnt_d       = cnt_q + 9'd1;
         err_d       = err_q | wlast_bad;
         if (last_beat) begin
            b_id_d   = id_q;
            b_resp_d = (err_q | wlast_bad) ? 2'b10 : 2'b00;
         end
      end
   end

   always_comb begin
      aw_ready  = aresetn & run_q & (state_q == IDLE);
      w_ready   = aresetn & (state_q == DATA);
      b_valid   = aresetn & (state_q == RESP);
      b_id      = b_id_q & {ID_W{aresetn}};
      b_resp    = b_resp_q & {2{aresetn}};
      ram_we    = ram_we_q & aresetn;
      ram_addr  = ram_addr_q & {WA_W{aresetn}};
      ram_wdata = ram_wdata_q & {DATA_W{aresetn}};
      ram_wstrb = ram_wstrb_q & {BYTES{aresetn}};
   end

endmodule
